// File: rtl/sram_responder.sv
// sram_responder: pin-level asynchronous-SRAM model backed by internal word storage.
// Clears storage after reset, answers reads after READ_LAT edges and commits writes on WE_n release.
module sram_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] ramAddr_i,
    input  logic        CE_n_i,
    input  logic        WE_n_i,
    input  logic        OE_n_i,
    input  logic [3:0]  be_n_i,
    inout  wire  [31:0] data_io,
    output logic        init_done_o,
    output logic        error_o,
    output logic [15:0] write_cnt_o
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CLR_W  = DEPTH_LOG2 + 1;
    localparam int unsigned LAT_W  = 2;
    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        CLEAR    = 3'd0,
        IDLE     = 3'd1,
        RD_WAIT  = 3'd2,
        RD_DRIVE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [CLR_W-1:0]        clr_cnt_q;
    logic [LAT_W-1:0]        lat_cnt_q;
    logic [LAT_W-1:0]        lat_cnt_d;
    logic [DEPTH_LOG2-1:0]   rd_idx_q;
    logic [DEPTH_LOG2-1:0]   rd_idx_d;
    logic [DEPTH_LOG2-1:0]   wr_idx_q;
    logic [LANES-1:0]        wr_be_n_q;
    logic [DATA_W-1:0]       wr_data_q;
    logic [LANES-1:0]        lane_oe_q;
    logic [LANES-1:0]        lane_oe_d;
    logic [DATA_W-1:0]       rd_data_q;

    logic [DATA_W-1:0]       mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   pin_idx;
    logic                    req_wr;
    logic                    req_rd;
    logic                    req_err;
    logic                    addr_moved;
    logic [LAT_W-1:0]        lat_load;

    logic                    clr_we;
    logic                    latch_wr;
    logic                    commit;
    logic                    rd_fetch;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_widx;
    logic [DATA_W-1:0]       mem_wdata;
    logic [LANES-1:0]        mem_wbe;

    logic                    unused_addr_hi;

    // Upper address bits alias onto the implemented storage.
    assign unused_addr_hi = ^ramAddr_i[19:DEPTH_LOG2];

    // Pin decode; a write request wins over a simultaneous read request.
    assign pin_idx    = ramAddr_i[DEPTH_LOG2-1:0];
    assign req_wr     = ~CE_n_i & ~WE_n_i;
    assign req_rd     = ~CE_n_i & ~OE_n_i & WE_n_i;
    assign req_err    = req_wr & ~OE_n_i;
    assign addr_moved = (pin_idx != rd_idx_q);
    assign lat_load   = LAT_W'(READ_LAT - 1);

    // State register; reset restarts the storage clear from any state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision from the sampled pins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q[DEPTH_LOG2]) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_wr) begin
                    state_d = WR_HOLD;
                end else if (req_rd) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (req_wr) begin
                    state_d = WR_HOLD;
                end else if (req_rd) begin
                    if (addr_moved) begin
                        state_d = RD_WAIT;
                    end else if (lat_cnt_q == '0) begin
                        state_d = RD_DRIVE;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_DRIVE: begin
                if (req_wr) begin
                    state_d = WR_HOLD;
                end else if (req_rd) begin
                    state_d = addr_moved ? RD_WAIT : RD_DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_HOLD: begin
                state_d = req_wr ? WR_HOLD : IDLE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Per-state controls: latency counter, read address, lane drive, write latch and commit.
    always_comb begin
        lat_cnt_d = lat_cnt_q;
        rd_idx_d  = rd_idx_q;
        lane_oe_d = '0;
        clr_we    = 1'b0;
        latch_wr  = 1'b0;
        commit    = 1'b0;
        rd_fetch  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = ~clr_cnt_q[DEPTH_LOG2];
            end
            IDLE, RD_WAIT, RD_DRIVE: begin
                latch_wr = req_wr;
                if (state_d == RD_WAIT) begin
                    if (state_q == IDLE || addr_moved) begin
                        rd_idx_d  = pin_idx;
                        lat_cnt_d = lat_load;
                    end else begin
                        lat_cnt_d = LAT_W'(lat_cnt_q - 1'b1);
                    end
                end
                if (state_d == RD_DRIVE) begin
                    rd_fetch  = 1'b1;
                    lane_oe_d = ~be_n_i;
                end
            end
            WR_HOLD: begin
                latch_wr = req_wr;
                commit   = ~req_wr;
            end
            default: begin
                lat_cnt_d = lat_cnt_q;
            end
        endcase
    end

    // Single storage write port shared by the clear walk and write commits.
    assign mem_we    = rst & (clr_we | commit);
    assign mem_widx  = clr_we ? clr_cnt_q[DEPTH_LOG2-1:0] : wr_idx_q;
    assign mem_wdata = clr_we ? '0 : wr_data_q;
    assign mem_wbe   = clr_we ? '1 : ~wr_be_n_q;

    // Storage array; a read fetch and a commit never share an edge, so no bypass is needed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (mem_wbe[k]) begin
                    mem[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
        if (rd_fetch) begin
            rd_data_q <= mem[pin_idx];
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            wr_be_n_q   <= '1;
            wr_data_q   <= '0;
            lane_oe_q   <= '0;
            init_done_o <= 1'b0;
            error_o     <= 1'b0;
            write_cnt_o <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            rd_idx_q  <= rd_idx_d;
            lane_oe_q <= lane_oe_d;
            if (clr_we) begin
                clr_cnt_q <= CLR_W'(clr_cnt_q + 1'b1);
            end
            if (latch_wr) begin
                wr_idx_q  <= pin_idx;
                wr_be_n_q <= be_n_i;
                wr_data_q <= data_io;
            end
            if (commit) begin
                write_cnt_o <= CNT_W'(write_cnt_o + 1'b1);
            end
            if (state_q != CLEAR && req_err) begin
                error_o <= 1'b1;
            end
            if (state_q == CLEAR && state_d == IDLE) begin
                init_done_o <= 1'b1;
            end
        end
    end

    // Each byte lane drives only while its registered enable is set.
    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        assign data_io[8*g +: 8] = lane_oe_q[g] ? rd_data_q[8*g +: 8] : 8'bz;
    end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed vector table, reset sequences and randomized transactions
// against a transaction-level memory model. Undriven bus bits are pulled high.
module tb_sram_responder;

    localparam int unsigned DEPTH_LOG2 = 12;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned LAT        = 3;
    localparam logic [31:0] ZBUS       = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] addr;
    logic        ce_n;
    logic        we_n;
    logic        oe_n;
    logic [3:0]  be_n;
    wire  [31:0] data_io;
    logic        init_done;
    logic        err;
    logic [15:0] wcnt;

    logic        tb_oe;
    logic [31:0] tb_wdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [DEPTH];
    int          model_cnt;

    assign data_io = tb_oe ? tb_wdata : 32'bz;
    for (genvar i = 0; i < 32; i++) begin : g_pu
        pullup (data_io[i]);
    end

    always #5 clk = ~clk;

    sram_responder #(.DEPTH_LOG2(DEPTH_LOG2), .READ_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ramAddr_i  (addr),
        .CE_n_i     (ce_n),
        .WE_n_i     (we_n),
        .OE_n_i     (oe_n),
        .be_n_i     (be_n),
        .data_io    (data_io),
        .init_done_o(init_done),
        .error_o    (err),
        .write_cnt_o(wcnt)
    );

    typedef struct {
        logic        ce_n;
        logic        we_n;
        logic        oe_n;
        logic [3:0]  be_n;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic w, logic o, logic [3:0] b, logic [19:0] a,
                                logic [31:0] d, logic [31:0] ed, logic [15:0] ec, logic ee);
        vec_t v;
        v.ce_n = c; v.we_n = w; v.oe_n = o; v.be_n = b; v.addr = a; v.wdata = d;
        v.exp_data = ed; v.exp_cnt = ec; v.exp_err = ee;
        return v;
    endfunction

    function automatic logic [31:0] lanes(logic [31:0] word, logic [3:0] bn);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = bn[k] ? 8'hFF : word[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] bn);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = bn[k] ? old[8*k +: 8] : nw[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rword();
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'($urandom_range(0, 254));
        return r;
    endfunction

    function automatic logic [19:0] raddr();
        return 20'($urandom) & 20'hFF03F;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pins(logic c, logic w, logic o, logic [3:0] b, logic [19:0] a, logic [31:0] d);
        ce_n = c; we_n = w; oe_n = o; be_n = b; addr = a;
        tb_wdata = d;
        tb_oe = ~c & ~w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pins(1'b1, 1'b1, 1'b1, 4'hF, 20'h0, 32'h0);
    endtask

    // Release reset and count edges after the release edge until init_done rises.
    task automatic clear_wait(string nm);
        int k;
        idle();
        rst = 1'b1;
        step();
        chk({nm, "_init_lo"}, 32'(init_done), 32'd0);
        k = 0;
        while (!init_done && k < 5000) begin
            step();
            k++;
        end
        chk({nm, "_len"}, 32'(k), 32'd4096);
    endtask

    // Read held for `hold` edges with a fixed be_n, expected word known up front.
    task automatic rd_fixed(string nm, logic [19:0] a, logic [3:0] b, int hold, logic [31:0] word);
        for (int j = 0; j < hold; j++) begin
            pins(1'b0, 1'b1, 1'b0, b, a, 32'h0);
            step();
            chk(nm, data_io, (j < int'(LAT)) ? ZBUS : lanes(word, b));
        end
        idle();
        step();
        chk({nm, "_rel"}, data_io, ZBUS);
    endtask

    task automatic wr_one(logic [19:0] a, logic [3:0] b, logic [31:0] d);
        pins(1'b0, 1'b0, 1'b1, b, a, d);
        step();
        idle();
        step();
        model[a[DEPTH_LOG2-1:0]] = merge(model[a[DEPTH_LOG2-1:0]], d, b);
        model_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        tb_oe = 1'b0;
        tb_wdata = '0;
        idle();

        // Reset and first clear
        step();
        step();
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(wcnt), 32'd0);
        chk("rst_bus", data_io, ZBUS);
        clear_wait("clear1");
        rd_fixed("clr_rd_abc", 20'h00ABC, 4'h0, LAT + 1, 32'h0);
        chk("clr_cnt", 32'(wcnt), 32'd0);

        // Directed vector table, one row per edge
        vecs.push_back(mk(1,1,1,4'hF,20'h0,    32'h0,        ZBUS,         16'd0, 1'b0));
        vecs.push_back(mk(0,0,1,4'h0,20'h00010,32'hDEADBEEF, 32'hDEADBEEF, 16'd0, 1'b0));
        vecs.push_back(mk(1,1,1,4'hF,20'h0,    32'h0,        ZBUS,         16'd1, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00010,32'h0,        ZBUS,         16'd1, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00010,32'h0,        ZBUS,         16'd1, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00010,32'h0,        ZBUS,         16'd1, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00010,32'h0,        32'hDEADBEEF, 16'd1, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00010,32'h0,        32'hDEADBEEF, 16'd1, 1'b0));
        vecs.push_back(mk(1,1,1,4'hF,20'h0,    32'h0,        ZBUS,         16'd1, 1'b0));
        vecs.push_back(mk(0,0,1,4'h0,20'h00020,32'h11223344, 32'h11223344, 16'd1, 1'b0));
        vecs.push_back(mk(1,1,1,4'hF,20'h0,    32'h0,        ZBUS,         16'd2, 1'b0));
        vecs.push_back(mk(0,0,1,4'hA,20'h00020,32'hAABBCCDD, 32'hAABBCCDD, 16'd2, 1'b0));
        vecs.push_back(mk(1,1,1,4'hF,20'h0,    32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'hC,20'h00020,32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'hC,20'h00020,32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'hC,20'h00020,32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'hC,20'h00020,32'h0,        32'hFFFF33DD, 16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'h3,20'h00020,32'h0,        32'h11BBFFFF, 16'd3, 1'b0));
        vecs.push_back(mk(1,1,1,4'hF,20'h0,    32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00010,32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00020,32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00020,32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00020,32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,1,0,4'h0,20'h00020,32'h0,        32'h11BB33DD, 16'd3, 1'b0));
        vecs.push_back(mk(1,1,1,4'hF,20'h0,    32'h0,        ZBUS,         16'd3, 1'b0));
        vecs.push_back(mk(0,0,0,4'h0,20'h00030,32'h00000005, 32'h00000005, 16'd3, 1'b1));
        vecs.push_back(mk(1,1,1,4'hF,20'h0,    32'h0,        ZBUS,         16'd4, 1'b1));
        vecs.push_back(mk(0,1,0,4'h0,20'h00030,32'h0,        ZBUS,         16'd4, 1'b1));
        vecs.push_back(mk(0,1,0,4'h0,20'h00030,32'h0,        ZBUS,         16'd4, 1'b1));
        vecs.push_back(mk(0,1,0,4'h0,20'h00030,32'h0,        ZBUS,         16'd4, 1'b1));
        vecs.push_back(mk(0,1,0,4'h0,20'h00030,32'h0,        32'h00000005, 16'd4, 1'b1));
        vecs.push_back(mk(1,1,1,4'hF,20'h0,    32'h0,        ZBUS,         16'd4, 1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            pins(vecs[i].ce_n, vecs[i].we_n, vecs[i].oe_n, vecs[i].be_n, vecs[i].addr, vecs[i].wdata);
            step();
            chk($sformatf("vec%0d_data", i), data_io, vecs[i].exp_data);
            chk($sformatf("vec%0d_cnt", i), 32'(wcnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
        end

        // Reset while a write is pending: discarded, counters and storage re-zeroed
        pins(1'b0, 1'b0, 1'b1, 4'h0, 20'h00040, 32'h12345678);
        step();
        chk("pend_cnt", 32'(wcnt), 32'd4);
        rst = 1'b0;
        step();
        chk("mid_rst_cnt", 32'(wcnt), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_init", 32'(init_done), 32'd0);
        idle();
        step();
        chk("mid_rst_bus", data_io, ZBUS);
        clear_wait("clear2");
        chk("clear2_cnt", 32'(wcnt), 32'd0);
        rd_fixed("rz_40", 20'h00040, 4'h0, LAT + 1, 32'h0);
        rd_fixed("rz_10", 20'h00010, 4'h0, LAT + 1, 32'h0);

        // Address aliasing above DEPTH_LOG2
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
        model_cnt = 0;
        wr_one(20'h01005, 4'h0, 32'h0A1B2C3D);
        chk("alias_cnt", 32'(wcnt), 32'd1);
        rd_fixed("alias_rd", 20'h00005, 4'h0, LAT + 2, 32'h0A1B2C3D);

        // Randomized transactions against the word model
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                int h;
                logic [19:0] a;
                logic [3:0]  b;
                logic [31:0] d;
                h = $urandom_range(1, 3);
                a = '0; b = '0; d = '0;
                for (int j = 0; j < h; j++) begin
                    a = raddr();
                    b = 4'($urandom);
                    d = rword();
                    pins(1'b0, 1'b0, 1'b1, b, a, d);
                    step();
                end
                chk("rnd_wr_hold_cnt", 32'(wcnt), 32'(16'(model_cnt)));
                idle();
                step();
                model[a[DEPTH_LOG2-1:0]] = merge(model[a[DEPTH_LOG2-1:0]], d, b);
                model_cnt++;
                chk("rnd_wr_cnt", 32'(wcnt), 32'(16'(model_cnt)));
                chk("rnd_err", 32'(err), 32'd0);
            end else begin
                logic [19:0] a1;
                logic [19:0] a2;
                int          chg;
                int          hold;
                a1 = raddr();
                a2 = raddr();
                while (a2[DEPTH_LOG2-1:0] == a1[DEPTH_LOG2-1:0]) a2 = raddr();
                if ($urandom_range(0, 3) == 0) begin
                    chg  = $urandom_range(1, LAT + 1);
                    hold = chg + int'(LAT) + $urandom_range(0, 1);
                end else begin
                    chg  = 1000;
                    hold = int'(LAT) + $urandom_range(0, 2);
                end
                for (int j = 0; j < hold; j++) begin
                    logic [19:0] ca;
                    logic [3:0]  b;
                    int          s;
                    ca = (j >= chg) ? a2 : a1;
                    s  = (j >= chg) ? chg : 0;
                    b  = 4'($urandom);
                    pins(1'b0, 1'b1, 1'b0, b, ca, 32'h0);
                    step();
                    chk("rnd_rd", data_io,
                        (j - s >= int'(LAT)) ? lanes(model[ca[DEPTH_LOG2-1:0]], b) : ZBUS);
                end
                idle();
                step();
                chk("rnd_rd_rel", data_io, ZBUS);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
